// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding fetch at a time over a
// req/gnt/rvalid memory port, and presents each instruction to decode via valid/ready.
package params_pkg;
    parameter int unsigned ADDR_WIDTH  = 8;
    parameter int unsigned INSTR_WIDTH = 32;
    parameter int unsigned MEM_SIZE    = 256;
endpackage

module fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH  = params_pkg::ADDR_WIDTH,
    parameter int unsigned INSTR_WIDTH = params_pkg::INSTR_WIDTH,
    parameter int unsigned MEM_SIZE    = params_pkg::MEM_SIZE,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   mem_req_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
    output logic                   dec_valid_o,
    input  logic                   dec_ready_i,
    output logic [INSTR_WIDTH-1:0] dec_instr_o,
    output logic [ADDR_WIDTH-1:0]  dec_pc_o,
    output logic [ADDR_WIDTH-1:0]  pc_o
);

    localparam logic [ADDR_WIDTH:0]   MemSizeW = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ResetPc  = ADDR_WIDTH'(RESET_PC % MEM_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDrop,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic                   dec_valid_q, dec_valid_d;
    logic [INSTR_WIDTH-1:0] dec_instr_q, dec_instr_d;
    logic [ADDR_WIDTH-1:0]  dec_pc_q, dec_pc_d;
    logic                   seen_gnt_q, seen_gnt_d;

    logic [ADDR_WIDTH:0]    pc_inc_full;
    logic [ADDR_WIDTH-1:0]  pc_inc;
    logic [ADDR_WIDTH-1:0]  redirect_pc;

    // Extra bit keeps the increment of MEM_SIZE-1 from overflowing before the reduction.
    assign pc_inc_full = {1'b0, req_pc_q} + (ADDR_WIDTH + 1)'(1);
    assign pc_inc      = ADDR_WIDTH'(pc_inc_full % MemSizeW);
    assign redirect_pc = ADDR_WIDTH'({1'b0, redirect_pc_i} % MemSizeW);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        dec_valid_d = dec_valid_q;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        seen_gnt_d  = seen_gnt_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (redirect_i) begin
                    pc_d = redirect_pc;
                end
            end
            StReq: begin
                if (mem_gnt_i) begin
                    seen_gnt_d = 1'b1;
                    if (redirect_i) begin
                        pc_d    = redirect_pc;
                        state_d = StDrop;
                    end else begin
                        req_pc_d = pc_q;
                        state_d  = StWait;
                    end
                end else if (redirect_i) begin
                    pc_d = redirect_pc;
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    if (redirect_i) begin
                        pc_d    = redirect_pc;
                        state_d = StReq;
                    end else begin
                        dec_instr_d = mem_rdata_i;
                        dec_pc_d    = req_pc_q;
                        dec_valid_d = 1'b1;
                        pc_d        = pc_inc;
                        state_d     = StHold;
                    end
                end else if (redirect_i) begin
                    pc_d    = redirect_pc;
                    state_d = StDrop;
                end
            end
            StDrop: begin
                dec_valid_d = 1'b0;
                if (redirect_i) begin
                    pc_d = redirect_pc;
                end
                if (mem_rvalid_i) begin
                    state_d = StReq;
                end
            end
            StHold: begin
                if (redirect_i || dec_ready_i) begin
                    dec_valid_d = 1'b0;
                    state_d     = StReq;
                end
                if (redirect_i) begin
                    pc_d = redirect_pc;
                end
            end
            default: begin
                state_d     = StIdle;
                dec_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pc_q        <= ResetPc;
            req_pc_q    <= '0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= '0;
            dec_pc_q    <= '0;
            seen_gnt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            dec_valid_q <= dec_valid_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            seen_gnt_q  <= seen_gnt_d;
        end
    end

    assign mem_req_o   = (state_q == StReq);
    assign mem_addr_o  = pc_q;
    assign pc_o        = pc_q;
    assign dec_valid_o = dec_valid_q;
    assign dec_instr_o = dec_instr_q;
    assign dec_pc_o    = dec_pc_q;

    // Responses still in flight across a reset land before the first new grant; only
    // responses after that point must line up with WAIT/DROP.
    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_rvalid_i && seen_gnt_q) |-> (state_q == StWait || state_q == StDrop));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised and directed bench for fetch_ctrl with a transaction-level fetch model.
module tb_fetch_ctrl;

    localparam int unsigned AW  = 8;
    localparam int unsigned IW  = 32;
    localparam int unsigned M   = 8;
    localparam int unsigned RPC = 0;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [IW-1:0] mem_rdata_i;
    logic          dec_valid_o;
    logic          dec_ready_i;
    logic [IW-1:0] dec_instr_o;
    logic [AW-1:0] dec_pc_o;
    logic [AW-1:0] pc_o;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .MEM_SIZE   (M),
        .RESET_PC   (RPC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .dec_valid_o  (dec_valid_o),
        .dec_ready_i  (dec_ready_i),
        .dec_instr_o  (dec_instr_o),
        .dec_pc_o     (dec_pc_o),
        .pc_o         (pc_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus policy plus one-shot overrides (-1 / 0 means unused).
    int            gnt_pct, rd_pct, ready_pct, lat_min, lat_max;
    bit            addr_data;
    int            ovr_gnt = -1, ovr_rd = -1, ovr_lat = 0;
    int            ovr_rd_pc = 0;
    bit            ovr_stale = 0;
    bit            ovr_data_en = 0;
    logic [IW-1:0] ovr_data;

    // Model: next address the fetcher must request, what decode must see, memory in flight.
    int            exp_fetch;
    bit            exp_valid;
    int            exp_dpc;
    logic [IW-1:0] exp_dinstr;
    bit            idle_cyc;
    bit            pend_v, pend_live;
    int            pend_wait, pend_addr;
    logic [IW-1:0] pend_data;

    int            cyc;
    bit            prev_valid;
    int            obs_pc[$];
    logic [IW-1:0] obs_ins[$];
    int            obs_cyc[$];
    int            gnt_addr[$];

    task automatic set_knobs(input int g, input int r, input int rdy, input int lmin,
                             input int lmax, input bit ad);
        gnt_pct = g; rd_pct = r; ready_pct = rdy; lat_min = lmin; lat_max = lmax;
        addr_data = ad;
    endtask

    task automatic reset_assert();
        rst_ni = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        dec_ready_i = 1'b0; mem_rdata_i = '0;
        #1;
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        exp_fetch = RPC % M; exp_valid = 0; exp_dpc = 0; exp_dinstr = '0;
        idle_cyc = 1; pend_v = 0; pend_live = 0; pend_wait = 0;
        prev_valid = 0; cyc = 0;
        obs_pc.delete(); obs_ins.delete(); obs_cyc.delete(); gnt_addr.delete();
    endtask

    task automatic tick();
        bit g, rv, rd, rdy, nv, er;
        int rpc, lat;
        @(negedge clk);
        cyc++;
        er = !pend_v && !exp_valid && !idle_cyc;
        n_checks++;
        if (dec_valid_o !== exp_valid) begin
            n_errors++;
            $display("FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, dec_valid_o, exp_valid);
        end
        n_checks++;
        if (mem_req_o !== er) begin
            n_errors++;
            $display("FAIL mem_req cyc=%0d got=%b exp=%b", cyc, mem_req_o, er);
        end
        n_checks++;
        if (pc_o !== AW'(exp_fetch)) begin
            n_errors++;
            $display("FAIL pc_o cyc=%0d got=%0d exp=%0d", cyc, pc_o, exp_fetch);
        end
        if (mem_req_o === 1'b1) begin
            n_checks++;
            if (mem_addr_o !== AW'(exp_fetch)) begin
                n_errors++;
                $display("FAIL mem_addr cyc=%0d got=%0d exp=%0d", cyc, mem_addr_o, exp_fetch);
            end
        end
        if (exp_valid) begin
            n_checks++;
            if (dec_pc_o !== AW'(exp_dpc) || dec_instr_o !== exp_dinstr) begin
                n_errors++;
                $display("FAIL dec_data cyc=%0d got=(%0d,%h) exp=(%0d,%h)", cyc, dec_pc_o,
                         dec_instr_o, exp_dpc, exp_dinstr);
            end
        end
        if (dec_valid_o === 1'b1 && !prev_valid) begin
            obs_pc.push_back(int'(dec_pc_o));
            obs_ins.push_back(dec_instr_o);
            obs_cyc.push_back(cyc);
        end
        prev_valid = (dec_valid_o === 1'b1);

        g   = (mem_req_o === 1'b1) &&
              ((ovr_gnt >= 0) ? (ovr_gnt == 1) : ($urandom_range(99) < gnt_pct));
        rv  = pend_v && (pend_wait == 0);
        rd  = (ovr_rd >= 0) ? (ovr_rd == 1) : ($urandom_range(99) < rd_pct);
        rpc = (ovr_rd >= 0) ? ovr_rd_pc : int'($urandom_range(255));
        rdy = $urandom_range(99) < ready_pct;
        mem_gnt_i     = g;
        redirect_i    = rd;
        redirect_pc_i = AW'(rpc);
        dec_ready_i   = rdy;
        mem_rvalid_i  = rv || ovr_stale;
        mem_rdata_i   = rv ? pend_data : (ovr_stale ? IW'(32'hDEAD) : IW'($urandom));

        nv = exp_valid;
        if (exp_valid && (rdy || rd)) nv = 0;
        if (rv) begin
            if (pend_live && !rd) begin
                nv         = 1;
                exp_dpc    = pend_addr;
                exp_dinstr = pend_data;
                exp_fetch  = (pend_addr + 1) % M;
            end
            pend_v = 0;
        end else if (pend_v) begin
            pend_wait--;
        end
        if (g) begin
            gnt_addr.push_back(int'(mem_addr_o));
            lat       = (ovr_lat > 0) ? ovr_lat : int'($urandom_range(lat_max, lat_min));
            pend_v    = 1;
            pend_live = 1;
            pend_wait = lat - 1;
            pend_addr = exp_fetch;
            pend_data = ovr_data_en ? ovr_data
                      : (addr_data ? IW'(32'hA0 + exp_fetch) : IW'($urandom));
            ovr_lat     = 0;
            ovr_data_en = 0;
        end
        if (rd) begin
            exp_fetch = rpc % M;
            pend_live = 0;
        end
        exp_valid = nv;
        idle_cyc  = 0;
        ovr_gnt = -1; ovr_rd = -1; ovr_stale = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_assert();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mem_req_o !== 1'b0 || dec_valid_o !== 1'b0 || dec_instr_o !== '0 ||
            dec_pc_o !== '0 || pc_o !== AW'(RPC % M)) begin
            n_errors++;
            $display("FAIL reset_values got req=%b val=%b ins=%h dpc=%0d pc=%0d exp all 0, pc=%0d",
                     mem_req_o, dec_valid_o, dec_instr_o, dec_pc_o, pc_o, RPC % M);
        end
        set_knobs(100, 0, 100, 1, 1, 1);
        reset_release();
        repeat (2) tick();
    endtask

    task automatic test_sequential();
        reset_assert();
        reset_release();
        set_knobs(100, 0, 100, 1, 1, 1);
        repeat (12) tick();
        n_checks++;
        if (obs_pc.size() < 3) begin
            n_errors++;
            $display("FAIL seq_count got=%0d exp>=3", obs_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_pc[i] != i || obs_ins[i] !== IW'(32'hA0 + i) || gnt_addr[i] != i) begin
                    n_errors++;
                    $display("FAIL seq_item%0d got=(%0d,%h,gnt %0d) exp=(%0d,%h,gnt %0d)", i,
                             obs_pc[i], obs_ins[i], gnt_addr[i], i, 32'hA0 + i, i);
                end
            end
            n_checks++;
            if (obs_cyc[1] - obs_cyc[0] != 3 || obs_cyc[2] - obs_cyc[1] != 3) begin
                n_errors++;
                $display("FAIL seq_spacing got=%0d,%0d exp=3,3", obs_cyc[1] - obs_cyc[0],
                         obs_cyc[2] - obs_cyc[1]);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_seq[4] = '{6, 7, 0, 1};
        reset_assert();
        reset_release();
        set_knobs(100, 0, 100, 1, 1, 1);
        tick();
        ovr_rd = 1; ovr_rd_pc = 6;
        tick();
        repeat (20) tick();
        n_checks++;
        if (obs_pc.size() < 4) begin
            n_errors++;
            $display("FAIL wrap_count got=%0d exp>=4", obs_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (obs_pc[i] != exp_seq[i]) begin
                    n_errors++;
                    $display("FAIL wrap_pc%0d got=%0d exp=%0d", i, obs_pc[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_gnt_delay();
        reset_assert();
        reset_release();
        set_knobs(100, 0, 100, 1, 1, 1);
        tick();
        ovr_gnt = 0; tick();
        ovr_gnt = 0; ovr_rd = 1; ovr_rd_pc = 5; tick();
        ovr_gnt = 0; tick();
        tick();
        n_checks++;
        if (gnt_addr.size() != 1 || gnt_addr[0] != 5) begin
            n_errors++;
            $display("FAIL gnt_delay_addr got n=%0d addr=%0d exp n=1 addr=5", gnt_addr.size(),
                     (gnt_addr.size() > 0) ? gnt_addr[0] : -1);
        end
        repeat (6) tick();
        n_checks++;
        if (obs_pc.size() < 1 || obs_pc[0] != 5) begin
            n_errors++;
            $display("FAIL gnt_delay_dec got n=%0d exp first pc 5", obs_pc.size());
        end
    endtask

    task automatic test_redirect_wait();
        int seen_valid = 0;
        int dead_seen = 0;
        reset_assert();
        reset_release();
        set_knobs(100, 0, 100, 1, 1, 1);
        tick();
        ovr_lat = 3; ovr_data_en = 1; ovr_data = IW'(32'hDEAD);
        tick();
        ovr_rd = 1; ovr_rd_pc = 12;
        tick();
        repeat (2) begin
            tick();
            if (dec_valid_o === 1'b1) seen_valid++;
        end
        n_checks++;
        if (seen_valid != 0) begin
            n_errors++;
            $display("FAIL redir_wait_quiet got valid cycles=%0d exp=0", seen_valid);
        end
        repeat (10) tick();
        foreach (obs_ins[i]) if (obs_ins[i] === IW'(32'hDEAD)) dead_seen++;
        n_checks++;
        if (dead_seen != 0) begin
            n_errors++;
            $display("FAIL redir_wait_squash got dead presentations=%0d exp=0", dead_seen);
        end
        n_checks++;
        if (gnt_addr.size() < 2 || gnt_addr[1] != 12 % M) begin
            n_errors++;
            $display("FAIL redir_wait_next got n=%0d exp second grant at %0d", gnt_addr.size(),
                     12 % M);
        end
    endtask

    task automatic test_hold();
        logic [AW-1:0] snap_pc;
        logic [IW-1:0] snap_ins;
        int            waited = 0;
        reset_assert();
        reset_release();
        set_knobs(100, 0, 0, 1, 1, 1);
        while (dec_valid_o !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (dec_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_reach got valid=%b exp=1 within 20 cycles", dec_valid_o);
        end
        snap_pc  = dec_pc_o;
        snap_ins = dec_instr_o;
        repeat (4) begin
            tick();
            n_checks++;
            if (dec_valid_o !== 1'b1 || dec_pc_o !== snap_pc || dec_instr_o !== snap_ins) begin
                n_errors++;
                $display("FAIL hold_stable got=(%b,%0d,%h) exp=(1,%0d,%h)", dec_valid_o,
                         dec_pc_o, dec_instr_o, snap_pc, snap_ins);
            end
        end
        ovr_rd = 1; ovr_rd_pc = 3;
        tick();
        n_checks++;
        if (dec_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_redirect_drop got valid=%b exp=0", dec_valid_o);
        end
        ready_pct = 100;
        repeat (4) tick();
        n_checks++;
        if (gnt_addr.size() < 2 || gnt_addr[1] != 3) begin
            n_errors++;
            $display("FAIL hold_redirect_addr got n=%0d exp second grant at 3", gnt_addr.size());
        end
    endtask

    task automatic test_reset_in_wait();
        reset_assert();
        reset_release();
        set_knobs(100, 0, 100, 1, 1, 1);
        tick();
        ovr_lat = 6;
        tick();
        tick();
        reset_assert();
        n_checks++;
        if (mem_req_o !== 1'b0 || dec_valid_o !== 1'b0 || dec_instr_o !== '0 ||
            dec_pc_o !== '0 || pc_o !== AW'(RPC % M)) begin
            n_errors++;
            $display("FAIL reset_in_wait got req=%b val=%b ins=%h dpc=%0d pc=%0d exp zeros",
                     mem_req_o, dec_valid_o, dec_instr_o, dec_pc_o, pc_o);
        end
        reset_release();
        ovr_stale = 1; tick();
        ovr_stale = 1; ovr_gnt = 0; tick();
        repeat (8) tick();
        n_checks++;
        if (obs_pc.size() < 1 || obs_pc[0] != RPC % M || obs_ins[0] !== IW'(32'hA0 + RPC % M)) begin
            n_errors++;
            $display("FAIL reset_stale got n=%0d first=(%0d,%h) exp=(%0d,%h)", obs_pc.size(),
                     (obs_pc.size() > 0) ? obs_pc[0] : -1,
                     (obs_ins.size() > 0) ? obs_ins[0] : '0, RPC % M, 32'hA0 + RPC % M);
        end
    endtask

    task automatic test_random();
        reset_assert();
        reset_release();
        set_knobs(60, 8, 50, 1, 4, 0);
        repeat (3000) tick();
        n_checks++;
        if (obs_pc.size() < 50) begin
            n_errors++;
            $display("FAIL random_progress got presentations=%0d exp>=50", obs_pc.size());
        end
        set_knobs(100, 20, 80, 1, 2, 0);
        repeat (1500) tick();
    endtask

    initial begin
        rst_ni = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        dec_ready_i = 1'b0; mem_rdata_i = '0;
        test_reset();
        test_sequential();
        test_wrap();
        test_gnt_delay();
        test_redirect_wait();
        test_hold();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
